multicycle_controller: RTL and testbench

- Moore-style FSM that sequences the shared-memory, single-ALU multicycle RV32I datapath: one instruction per 3–5 states plus memory wait states.
- Decodes opcode/funct fields, drives every mux select, write strobe and the 3-bit ALU operation.
- Holds in memory states until `mem_ready` is high.
- Traps permanently on unsupported opcodes.

---
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// Moore sequencer for the shared-memory multicycle RV32I datapath; outputs are combinational from state (+ mem_ready/zero/op/funct).
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; unsupported opcodes latch into TRAP until reset.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    JAL      = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  state_t     cur_st, nxt_st;
  logic [1:0] aluop;
  logic       pc_we, mem_we, ir_we, rf_we;

  always_ff @(posedge clk) begin
    if (!rst_n) cur_st <= FETCH;
    else        cur_st <= nxt_st;
  end

  assign state = cur_st;

  always_comb begin
    nxt_st    = cur_st;
    pc_we     = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    case (cur_st)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) nxt_st = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nxt_st = MEMADR;
          OP_R:              nxt_st = EXECR;
          OP_I:              nxt_st = EXECI;
          OP_BR:             nxt_st = BRANCH;
          OP_JAL:            nxt_st = JAL;
          default:           nxt_st = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt_st  = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nxt_st = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rf_we     = 1'b1;
        nxt_st    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) nxt_st = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
        nxt_st  = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
        nxt_st  = ALUWB;
      end
      ALUWB: begin
        rf_we  = 1'b1;
        nxt_st = FETCH;
      end
      BRANCH: begin
        // funct3[0] distinguishes bne from beq
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        pc_we   = zero ^ funct3[0];
        nxt_st  = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        nxt_st  = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
        nxt_st  = TRAP;
      end
      default: nxt_st = FETCH;
    endcase
  end

  assign PCWrite  = rst_n & pc_we;
  assign MemWrite = rst_n & mem_we;
  assign IRWrite  = rst_n & ir_we;
  assign RegWrite = rst_n & rf_we;

  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BR:    ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Bench: each instruction is expanded into its expected per-cycle trace from its class, then replayed against the controller.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010,
                         A_OR  = 3'b011, A_SLT = 3'b101;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // strb = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal}; mux = {ResultSrc, ALUSrcA, ALUSrcB}
  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       z;
    logic [5:0] strb;
    logic [5:0] mux;
    logic [2:0] alu;
  } step_t;

  step_t q[$];
  int    total  = 0;
  int    passed = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic step_t mk(input logic [3:0] st, input logic mr, input logic z,
                               input logic [5:0] strb, input logic [5:0] mux,
                               input logic [2:0] alu);
    step_t s;
    s.st = st; s.mr = mr; s.z = z; s.strb = strb; s.mux = mux; s.alu = alu;
    return s;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == OP_R && f7) ? A_SUB : A_ADD;
    if (f3 == 3'b010) return A_SLT;
    if (f3 == 3'b110) return A_OR;
    if (f3 == 3'b111) return A_AND;
    return A_ADD;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == OP_STORE) return 2'b01;
    if (o == OP_BR)    return 2'b10;
    if (o == OP_JAL)   return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Expected trace of one instruction: fetch (with wf stall cycles), decode, then its class-specific tail.
  task automatic add_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm);
    step_t aluwb;
    aluwb = mk(4'd8, rb(), rb(), 6'b000010, 6'b00_00_00, A_ADD);
    for (int i = 0; i < wf; i++) q.push_back(mk(4'd0, 1'b0, rb(), 6'b000000, 6'b10_00_10, A_ADD));
    q.push_back(mk(4'd0, 1'b1, rb(), 6'b100100, 6'b10_00_10, A_ADD));
    q.push_back(mk(4'd1, rb(), rb(), 6'b000000, 6'b00_01_01, A_ADD));
    case (o)
      OP_LOAD: begin
        q.push_back(mk(4'd2, rb(), rb(), 6'b000000, 6'b00_10_01, A_ADD));
        for (int i = 0; i < wm; i++) q.push_back(mk(4'd3, 1'b0, rb(), 6'b010000, 6'b00_00_00, A_ADD));
        q.push_back(mk(4'd3, 1'b1, rb(), 6'b010000, 6'b00_00_00, A_ADD));
        q.push_back(mk(4'd4, rb(), rb(), 6'b000010, 6'b01_00_00, A_ADD));
      end
      OP_STORE: begin
        q.push_back(mk(4'd2, rb(), rb(), 6'b000000, 6'b00_10_01, A_ADD));
        for (int i = 0; i < wm; i++) q.push_back(mk(4'd5, 1'b0, rb(), 6'b011000, 6'b00_00_00, A_ADD));
        q.push_back(mk(4'd5, 1'b1, rb(), 6'b011000, 6'b00_00_00, A_ADD));
      end
      OP_R: begin
        q.push_back(mk(4'd6, rb(), rb(), 6'b000000, 6'b00_10_00, exp_alu(o, f3, f7)));
        q.push_back(aluwb);
      end
      OP_I: begin
        q.push_back(mk(4'd7, rb(), rb(), 6'b000000, 6'b00_10_01, exp_alu(o, f3, f7)));
        q.push_back(aluwb);
      end
      OP_BR: q.push_back(mk(4'd9, rb(), z, {z ^ f3[0], 5'b00000}, 6'b00_10_00, A_SUB));
      OP_JAL: begin
        q.push_back(mk(4'd10, rb(), rb(), 6'b100000, 6'b00_01_10, A_ADD));
        q.push_back(aluwb);
      end
      default: for (int i = 0; i < 10; i++) q.push_back(mk(4'd11, rb(), rb(), 6'b000001, 6'b00_00_00, A_ADD));
    endcase
  endtask

  // Entered just after a falling edge; each step drives, checks, then waits for the next falling edge.
  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr;
      zero      = s.z;
      #1;
      chk($sformatf("state(op=%b)", op), 32'(state), 32'(s.st));
      chk($sformatf("strobes(st=%0d)", s.st), 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal}), 32'(s.strb));
      chk($sformatf("muxes(st=%0d)", s.st), 32'({ResultSrc, ALUSrcA, ALUSrcB}), 32'(s.mux));
      chk($sformatf("alucontrol(st=%0d f3=%b)", s.st, funct3), 32'(ALUControl), 32'(s.alu));
      chk($sformatf("immsrc(op=%b)", op), 32'(ImmSrc), 32'(exp_imm(op)));
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int wf, input int wm);
    op = o; funct3 = f3; funct7 = f7;
    add_instr(o, f3, f7, z, wf, wm);
    play();
  endtask

  logic [6:0] pool [6];

  initial begin
    pool = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL};
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    op = OP_LOAD; funct3 = 3'b000; funct7 = 1'b0;

    // Reset: strobes held low even while FETCH would otherwise fire
    @(negedge clk); #1;
    chk("rst_strobes_pre", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_fetch_muxes", 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}), 32'b0_10_00_10);
    rst_n = 1'b1;

    // Directed: lw, stalled sw, ALU decodes, branches, jal
    run(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 0);
    run(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 3);
    run(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
    run(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
    run(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
    run(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);

    // Unsupported opcode traps, reset recovers
    run(OP_BAD, 3'b000, 1'b0, 1'b0, 1, 0);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("trap_rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    chk("trap_rst_state", 32'(state), 32'd0);
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);

    // Reset asserted mid MEMREAD wait: back to FETCH, no register write
    op = OP_LOAD; funct3 = 3'b010; funct7 = 1'b0;
    add_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    play();
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("memrd_rst_state_before", 32'(state), 32'd3);
    chk("memrd_rst_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    chk("memrd_rst_state_after", 32'(state), 32'd0);
    chk("memrd_rst_regwrite_after", 32'(RegWrite), 32'd0);
    @(negedge clk);

    // Randomized instruction mix with random memory stalls
    for (int n = 0; n < 60; n++) begin
      run(pool[$urandom_range(0, 5)], 3'($urandom), rb(), rb(),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    mem_ready = 1'b0;
    #1;
    chk("final_state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
